// File: rtl/enc_8to3_evq_pkg.sv
// ---------------------------------------------------------------------------
// enc_8to3_evq_pkg
//  Shared widths, types and helpers for the 8-to-3 event encoder.
//  Contents:
//   EVT_W  - number of event lines (8)
//   ENC_W  - width of an index code (3)
//   CNT_W  - width of a popcount over the event lines (4, holds 0..8)
//   evt_t / code_t / cnt_t - vector typedefs for the above
//   popcount8() - number of set bits in an event vector
// ---------------------------------------------------------------------------
package enc_8to3_evq_pkg;

   localparam int EVT_W = 8;
   localparam int ENC_W = 3;
   localparam int CNT_W = 4;

   typedef logic [EVT_W-1:0] evt_t;
   typedef logic [ENC_W-1:0] code_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // Counts the set bits of an event vector; the result can reach 8, which is
   // why the count is one bit wider than an index code.
   function automatic cnt_t popcount8(input evt_t v);
      cnt_t acc;
      acc = '0;
      for (int i = 0; i < EVT_W; i++) begin
         acc = acc + cnt_t'(v[i]);
      end
      return acc;
   endfunction

endpackage

// File: rtl/enc_8to3_evq_if.sv
// ---------------------------------------------------------------------------
// enc_8to3_evq_if
//  Valid/ready channel carrying 3-bit index codes from the encoder to its
//  consumer.
//  Signals:
//   code_out  [2:0]  index of the granted event line
//   code_vld         code_out holds a code the consumer has not yet taken
//   code_rdy         consumer takes code_out on a clock where code_vld is high
//  Modports:
//   master  - encoder side (drives code_out/code_vld, reads code_rdy)
//   slave   - consumer side (reads code_out/code_vld, drives code_rdy)
// ---------------------------------------------------------------------------
interface enc_8to3_evq_if;
   import enc_8to3_evq_pkg::*;

   code_t code_out;
   logic  code_vld;
   logic  code_rdy;

   modport master (
      output code_out,
      output code_vld,
      input  code_rdy
   );

   modport slave (
      input  code_out,
      input  code_vld,
      output code_rdy
   );

endinterface

// File: rtl/enc_8to3_evq_pri_sel_8.sv
// ---------------------------------------------------------------------------
// pri_sel_8
//  Purely combinational rotating priority selector over 8 request bits.
//  The search starts at index 'base' and walks upward, wrapping from 7 back
//  to 0; the first set bit wins. Tying base to 0 gives plain fixed priority
//  with bit 0 highest.
//  Ports:
//   pending  [7:0]  in   request bits to choose from
//   base     [2:0]  in   index searched first
//   grant_1h [7:0]  out  one-hot mask of the winning bit (all zero if none)
//   idx      [2:0]  out  index of the winning bit (0 if none)
//   any             out  at least one request bit is set
// ---------------------------------------------------------------------------
module pri_sel_8
   import enc_8to3_evq_pkg::*;
(
   input  evt_t  pending,
   input  code_t base,
   output evt_t  grant_1h,
   output code_t idx,
   output logic  any
);

   // Walk the eight candidate positions in search order. The 3-bit sum wraps
   // naturally, so base+i visits base..7 and then 0..base-1. 'any' doubles as
   // the already-found flag so later candidates cannot override the winner.
   always_comb begin
      code_t cand;
      cand     = '0;
      grant_1h = '0;
      idx      = '0;
      any      = 1'b0;
      for (int i = 0; i < EVT_W; i++) begin
         cand = base + code_t'(i);
         if (!any && pending[cand]) begin
            any            = 1'b1;
            idx            = cand;
            grant_1h[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enc_8to3_evq.sv
// ---------------------------------------------------------------------------
// enc_8to3_evq
//  Turns 8 event lines into a stream of 3-bit index codes. Each event is
//  latched into a pending bit; one pending bit per cycle is granted by
//  priority and its index is presented over a valid/ready channel. An event
//  landing on a bit that is still pending is never merged silently: it sets
//  a sticky overrun flag.
//  Parameters:
//   EDGE_MODE  1: event = rising edge of a req_in bit; 0: event = bit high
//   RR_EN      0: fixed priority, bit 0 highest; 1: round-robin starting
//              just after the last granted index
//  Ports:
//   sys_clk          in   clock, all state on the rising edge
//   sys_rst_n        in   asynchronous active-low reset
//   req_in   [7:0]   in   event lines, synchronous to sys_clk
//   code_if          --   master side of the code channel
//                         (code_out[2:0], code_vld out; code_rdy in)
//   pend_cnt [3:0]   out  number of pending events, 0..8
//   ovr_flag         out  sticky overrun indicator
//   ovr_clr          in   synchronous clear of ovr_flag
// ---------------------------------------------------------------------------
module enc_8to3_evq
   import enc_8to3_evq_pkg::*;
#(
   parameter bit EDGE_MODE = 1'b1,
   parameter bit RR_EN     = 1'b0
)
(
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  evt_t                   req_in,
   enc_8to3_evq_if.master         code_if,
   output cnt_t                   pend_cnt,
   output logic                   ovr_flag,
   input  logic                   ovr_clr
);

   evt_t  req_d_q,    req_d_d;
   evt_t  pending_q,  pending_d;
   code_t code_out_q, code_out_d;
   logic  code_vld_q, code_vld_d;
   code_t rr_ptr_q,   rr_ptr_d;
   cnt_t  pend_cnt_q, pend_cnt_d;
   logic  ovr_flag_q, ovr_flag_d;

   evt_t  evt;
   logic  ld;
   code_t sel_base;
   evt_t  sel_grant;
   code_t sel_idx;
   logic  sel_any;
   evt_t  grant_1h;

   // Event detection. The previous-sample register resets to all ones so a
   // line that is already high when reset lifts does not look like a fresh
   // rising edge.
   always_comb begin
      req_d_d = req_in;
      if (EDGE_MODE) begin
         evt = req_in & ~req_d_q;
      end else begin
         evt = req_in;
      end
   end

   // The output slot can take a new code when it is empty or when its current
   // code is being accepted on this very edge.
   assign ld = ~code_vld_q | code_if.code_rdy;

   // Fixed priority is the rotating selector with its start pinned to bit 0.
   assign sel_base = RR_EN ? rr_ptr_q : '0;

   pri_sel_8 u_pri_sel (
      .pending  (pending_q),
      .base     (sel_base),
      .grant_1h (sel_grant),
      .idx      (sel_idx),
      .any      (sel_any)
   );

   // Only registered pending bits are candidates, so an event arriving this
   // cycle waits at least one cycle before it can be granted. A grant only
   // takes effect when the output slot can accept it.
   assign grant_1h = ld ? sel_grant : '0;

   // Pending bookkeeping and overrun detection. OR-ing evt after the clear
   // lets a bit that is granted and re-raised on the same edge stay pending,
   // and that case is deliberately not an overrun because the old event was
   // consumed. A new overrun beats a simultaneous clear request.
   always_comb begin
      evt_t ovr_hits;
      pending_d  = (pending_q & ~grant_1h) | evt;
      pend_cnt_d = popcount8(pending_d);
      ovr_hits   = evt & pending_q & ~grant_1h;
      ovr_flag_d = ovr_flag_q;
      if (|ovr_hits) begin
         ovr_flag_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_flag_d = 1'b0;
      end
   end

   // Output register and round-robin pointer. While the consumer stalls the
   // held code must not move, so nothing here changes unless ld is high. When
   // the slot drains with nothing pending, code_out keeps its last value and
   // only code_vld drops.
   always_comb begin
      code_out_d = code_out_q;
      code_vld_d = code_vld_q;
      rr_ptr_d   = rr_ptr_q;
      if (ld) begin
         if (sel_any) begin
            code_out_d = sel_idx;
            code_vld_d = 1'b1;
            rr_ptr_d   = sel_idx + code_t'(1);
         end else begin
            code_vld_d = 1'b0;
         end
      end
   end

   // State registers. Reset mid-operation throws away every pending event and
   // any code waiting in the output slot.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         req_d_q    <= '1;
         pending_q  <= '0;
         code_out_q <= '0;
         code_vld_q <= 1'b0;
         rr_ptr_q   <= '0;
         pend_cnt_q <= '0;
         ovr_flag_q <= 1'b0;
      end else begin
         req_d_q    <= req_d_d;
         pending_q  <= pending_d;
         code_out_q <= code_out_d;
         code_vld_q <= code_vld_d;
         rr_ptr_q   <= rr_ptr_d;
         pend_cnt_q <= pend_cnt_d;
         ovr_flag_q <= ovr_flag_d;
      end
   end

   assign code_if.code_out = code_out_q;
   assign code_if.code_vld = code_vld_q;
   assign pend_cnt         = pend_cnt_q;
   assign ovr_flag         = ovr_flag_q;

endmodule
